axi_region_remap_ctrl: RTL and testbench
========================================

Name: axi_region_remap_ctrl

Overview:
- Sequential, parametrised successor to the combinational region-match swap stage in the AXI node address-decode path.
- Holds a per-initiator remap table, programmable at runtime. Remaps match_region bits from a source initiator column onto a target column.
- Only commits a table update after draining outstanding transactions on the affected initiators. While draining, it stalls new transactions on those ports.

Parameters:
- N_INIT_PORT, 8, number of initiator ports (columns).
- N_REGION, 3, number of address regions (rows).
- LOG_N_INIT, 3, index width; must be ≥ clog2(N_INIT_PORT).
- CNT_W, 4, outstanding-transaction counter width per port.
- DRAIN_TIMEOUT, 256, max cycles spent in DRAIN before the update is aborted.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- match_region_int_i  in  [N_REGION][N_INIT_PORT]  decoded region match, pre-remap
- match_region_int_o  out  [N_REGION][N_INIT_PORT]  remapped region match
- txn_start_i  in  [N_INIT_PORT]  one-cycle pulse, transaction accepted on port
- txn_done_i  in  [N_INIT_PORT]  one-cycle pulse, transaction retired on port
- stall_o  out  [N_INIT_PORT]  node must not accept new transactions on port
- cfg_valid_i  in  1  config request valid
- cfg_ready_o  out  1  config request accepted when valid&ready
- cfg_port_i  in  LOG_N_INIT  target port of entry
- cfg_src_i  in  LOG_N_INIT  source port for entry
- cfg_en_i  in  1  1 = enable entry, 0 = clear entry
- cfg_done_o  out  1  one-cycle pulse, request finished
- cfg_err_o  out  1  valid with cfg_done_o: 1 = rejected or aborted
- cnt_err_o  out  1  sticky counter underflow/overflow flag

Behaviour:
Reset (async assert, sync deassert):
- All table entries disabled. Counters = 0. FSM = IDLE.
- stall_o = 0, cfg_ready_o = 1, cfg_done_o = 0, cfg_err_o = 0, cnt_err_o = 0.
- Reset mid-DRAIN or mid-APPLY discards the pending request with no done pulse.

Remap (combinational from match_region_int_i and the registered table), for every region r and port i:
- If entry[i].en: out[r][i] = in[r][entry[i].src].
- Else if i is the src of any enabled entry: out[r][i] = 0.
- Else: out[r][i] = in[r][i].
- A self-mapped entry (src == i) yields in[r][i]; the entry rule takes priority over the zeroing rule.

Counters (one per port):
- start only: +1. done only: −1. Both in the same cycle: unchanged.
- done at 0: count held, cnt_err_o set.
- start at 2^CNT_W−1: count saturates, cnt_err_o set.
- cnt_err_o clears only on reset.

FSM, IDLE / DRAIN / APPLY:
- IDLE:
  - cfg_ready_o = 1.
  - On accept, latch port, src, en.
  - Out-of-range index (≥ N_INIT_PORT): no state change; next cycle cfg_done_o = 1, cfg_err_o = 1.
  - Valid request: compute affected mask = {port, new src, current entry[port].src if enabled}, then go to DRAIN.
- DRAIN:
  - cfg_ready_o = 0. stall_o = affected mask. Timeout counter increments every cycle.
  - When all affected counters are 0: go to APPLY. The check is made on the registered count, so a start pulse in the same cycle is counted next cycle.
  - When the timeout counter reaches DRAIN_TIMEOUT: table unchanged; cfg_done_o = 1, cfg_err_o = 1 in the following cycle; return to IDLE.
- APPLY:
  - stall_o held. Entry written at the end of the cycle. Go to IDLE.
  - Next cycle: new mapping visible on outputs, cfg_done_o = 1, cfg_err_o = 0, stall_o = 0.
- Latency, quiescent ports: accept at edge T → DRAIN cycle T+1 → APPLY cycle T+2 → done and new map in cycle T+3.
- cfg_valid_i while not IDLE is ignored (ready low); the requester must hold it.
- The remap output is never glitched by a partial update: the table changes in a single edge.

Test Plan:
- Reset, then drive in[r] = 8'b1010_0101 for all r → out equals in; stall_o = 0; cfg_ready_o = 1.
- cfg port=5, src=2, en=1, all counters 0 → done with err=0 at T+3; out[r][5] = in[r][2], out[r][2] = 0; in = 8'h04 gives out = 8'h20.
- Port 2 count = 3, same request → stall_o = 8'h24 during DRAIN; three done pulses on port 2 → APPLY after the count reaches 0; done follows 2 cycles later.
- Port 2 count held at 1 → after 256 DRAIN cycles: done with err=1; table unchanged; stall_o returns to 0.
- cfg_port = 9 with N_INIT_PORT = 8, LOG_N_INIT = 4 → done with err=1 next cycle; no DRAIN entered.
- done pulse on an idle port → cnt_err_o = 1, sticky; rst_n low mid-DRAIN → table cleared, no cfg_done_o.

Source files
------------

// File: rtl/axi_region_remap_ctrl.sv
// Runtime-programmable initiator remap of region-match columns, with a drain
// handshake. A table update commits only after the affected ports go quiescent.

module axi_region_remap_cnt #(
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic done,
  output logic nz,
  output logic err
);
  logic [CNT_W-1:0] cnt;

  assign nz  = |cnt;
  assign err = (start & ~done & (&cnt)) | (done & ~start & ~(|cnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (start & ~done & ~(&cnt))  cnt <= cnt + 1'b1;
    else if (done & ~start & (|cnt))   cnt <= cnt - 1'b1;
  end
endmodule

module axi_region_remap_ctrl #(
  parameter int N_INIT_PORT   = 8,
  parameter int N_REGION      = 3,
  parameter int LOG_N_INIT    = 3,
  parameter int CNT_W         = 4,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]    match_region_int_i,
  output logic [N_REGION-1:0][N_INIT_PORT-1:0]    match_region_int_o,
  input  logic [N_INIT_PORT-1:0]                  txn_start_i,
  input  logic [N_INIT_PORT-1:0]                  txn_done_i,
  output logic [N_INIT_PORT-1:0]                  stall_o,
  input  logic                                    cfg_valid_i,
  output logic                                    cfg_ready_o,
  input  logic [LOG_N_INIT-1:0]                   cfg_port_i,
  input  logic [LOG_N_INIT-1:0]                   cfg_src_i,
  input  logic                                    cfg_en_i,
  output logic                                    cfg_done_o,
  output logic                                    cfg_err_o,
  output logic                                    cnt_err_o
);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [LOG_N_INIT:0] NP = (LOG_N_INIT+1)'(N_INIT_PORT);

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;
  typedef struct packed {
    logic [LOG_N_INIT-1:0] port;
    logic [LOG_N_INIT-1:0] src;
    logic                  en;
  } cfg_req_t;

  state_t                               state;
  cfg_req_t                             req;
  logic [N_INIT_PORT-1:0]               mask, new_mask, cnt_nz, cnt_err, src_hit;
  logic [N_INIT_PORT-1:0]               tbl_en;
  logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0] tbl_src;
  logic [TW-1:0]                        tcnt;
  logic                                 bad_idx, cur_en;
  logic [LOG_N_INIT-1:0]                cur_src;

  for (genvar g = 0; g < N_INIT_PORT; g++) begin : g_lane
    axi_region_remap_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk), .rst_n(rst_n), .start(txn_start_i[g]), .done(txn_done_i[g]),
      .nz(cnt_nz[g]), .err(cnt_err[g])
    );
  end

  // Enabled entries pull their source column; a source that was moved away is
  // zeroed unless it is itself the target of an enabled entry.
  always_comb begin
    src_hit = '0;
    for (int i = 0; i < N_INIT_PORT; i++)
      for (int j = 0; j < N_INIT_PORT; j++)
        if (tbl_en[i] && tbl_src[i] == LOG_N_INIT'(j)) src_hit[j] = 1'b1;
    for (int r = 0; r < N_REGION; r++)
      for (int i = 0; i < N_INIT_PORT; i++) begin
        match_region_int_o[r][i] = match_region_int_i[r][i];
        if (tbl_en[i]) begin
          match_region_int_o[r][i] = 1'b0;
          for (int j = 0; j < N_INIT_PORT; j++)
            if (tbl_src[i] == LOG_N_INIT'(j)) match_region_int_o[r][i] = match_region_int_i[r][j];
        end else if (src_hit[i]) begin
          match_region_int_o[r][i] = 1'b0;
        end
      end
  end

  always_comb begin
    cur_en  = 1'b0;
    cur_src = '0;
    for (int j = 0; j < N_INIT_PORT; j++)
      if (cfg_port_i == LOG_N_INIT'(j)) begin
        cur_en  = tbl_en[j];
        cur_src = tbl_src[j];
      end
    bad_idx = ({1'b0, cfg_port_i} >= NP) || (cfg_en_i && {1'b0, cfg_src_i} >= NP);
    for (int j = 0; j < N_INIT_PORT; j++)
      new_mask[j] = (cfg_port_i == LOG_N_INIT'(j)) || (cfg_en_i && cfg_src_i == LOG_N_INIT'(j)) ||
                    (cur_en && cur_src == LOG_N_INIT'(j));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_err_o <= 1'b0;
    else        cnt_err_o <= cnt_err_o | (|cnt_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req         <= '0;
      mask        <= '0;
      tcnt        <= '0;
      tbl_en      <= '0;
      tbl_src     <= '0;
      stall_o     <= '0;
      cfg_ready_o <= 1'b1;
      cfg_done_o  <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      cfg_done_o <= 1'b0;
      cfg_err_o  <= 1'b0;
      case (state)
        IDLE: if (cfg_valid_i) begin
          if (bad_idx) begin
            cfg_done_o <= 1'b1;
            cfg_err_o  <= 1'b1;
          end else begin
            req         <= '{port: cfg_port_i, src: cfg_src_i, en: cfg_en_i};
            mask        <= new_mask;
            stall_o     <= new_mask;
            tcnt        <= '0;
            cfg_ready_o <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          tcnt <= tcnt + 1'b1;
          if ((mask & cnt_nz) == '0) begin
            state <= APPLY;
          end else if (tcnt == TW'(DRAIN_TIMEOUT - 1)) begin
            state       <= IDLE;
            stall_o     <= '0;
            cfg_ready_o <= 1'b1;
            cfg_done_o  <= 1'b1;
            cfg_err_o   <= 1'b1;
          end
        end
        APPLY: begin
          for (int j = 0; j < N_INIT_PORT; j++)
            if (req.port == LOG_N_INIT'(j)) begin
              tbl_en[j]  <= req.en;
              tbl_src[j] <= req.src;
            end
          state       <= IDLE;
          stall_o     <= '0;
          cfg_ready_o <= 1'b1;
          cfg_done_o  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_region_remap_ctrl.sv
// Directed bench for axi_region_remap_ctrl: remap, drain, timeout, bad index,
// counter errors and reset during a pending update.

module tb_axi_region_remap_ctrl;
  localparam int N = 8, R = 3, L = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [R-1:0][N-1:0] min, mout;
  logic [N-1:0]       tstart, tdone, stall;
  logic               cvalid, cready, cen, cdone, cerr, cnterr;
  logic [L-1:0]       cport, csrc;

  int vecs = 0, errs = 0;

  axi_region_remap_ctrl #(.N_INIT_PORT(N), .N_REGION(R), .LOG_N_INIT(L), .CNT_W(4),
                          .DRAIN_TIMEOUT(256)) dut (
    .clk(clk), .rst_n(rst_n), .match_region_int_i(min), .match_region_int_o(mout),
    .txn_start_i(tstart), .txn_done_i(tdone), .stall_o(stall),
    .cfg_valid_i(cvalid), .cfg_ready_o(cready), .cfg_port_i(cport), .cfg_src_i(csrc),
    .cfg_en_i(cen), .cfg_done_o(cdone), .cfg_err_o(cerr), .cnt_err_o(cnterr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] v);
    for (int r = 0; r < R; r++) min[r] = v;
    #1;
  endtask

  task automatic issue(input int p, input int s, input logic e);
    cport = L'(p); csrc = L'(s); cen = e; cvalid = 1'b1;
    tick();
    cvalid = 1'b0;
  endtask

  task automatic pulse_start(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      tstart[p] = 1'b1;
      tick();
      tstart[p] = 1'b0;
    end
  endtask

  task automatic pulse_done(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      tdone[p] = 1'b1;
      tick();
      tdone[p] = 1'b0;
    end
  endtask

  task automatic test_reset();
    set_in(8'hA5);
    vecs++; if (stall !== 8'h00 || cready !== 1'b1) begin errs++;
      $display("FAIL reset_ctl stall=%h ready=%b want 00/1", stall, cready); end
    vecs++; if (cdone !== 1'b0 || cerr !== 1'b0 || cnterr !== 1'b0) begin errs++;
      $display("FAIL reset_flags done=%b err=%b cnterr=%b want 0/0/0", cdone, cerr, cnterr); end
    for (int r = 0; r < R; r++) begin
      vecs++; if (mout[r] !== 8'hA5) begin errs++;
        $display("FAIL reset_passthru r%0d got %h want a5", r, mout[r]); end
    end
  endtask

  task automatic test_map_quiescent();
    issue(5, 2, 1'b1);
    vecs++; if (stall !== 8'h24 || cready !== 1'b0 || cdone !== 1'b0) begin errs++;
      $display("FAIL q_drain stall=%h ready=%b done=%b want 24/0/0", stall, cready, cdone); end
    tick();
    vecs++; if (stall !== 8'h24 || cdone !== 1'b0) begin errs++;
      $display("FAIL q_apply stall=%h done=%b want 24/0", stall, cdone); end
    tick();
    vecs++; if (cdone !== 1'b1 || cerr !== 1'b0 || stall !== 8'h00 || cready !== 1'b1) begin errs++;
      $display("FAIL q_done done=%b err=%b stall=%h ready=%b want 1/0/00/1", cdone, cerr, stall, cready); end
    vecs++; if (mout[0] !== 8'hA1) begin errs++;
      $display("FAIL q_map_a5 got %h want a1", mout[0]); end
    set_in(8'h04);
    for (int r = 0; r < R; r++) begin
      vecs++; if (mout[r] !== 8'h20) begin errs++;
        $display("FAIL q_map_04 r%0d got %h want 20", r, mout[r]); end
    end
    tick();
    vecs++; if (cdone !== 1'b0) begin errs++;
      $display("FAIL q_done_pulse done=%b want 0", cdone); end
  endtask

  task automatic test_drain();
    pulse_start(2, 3);
    issue(5, 2, 1'b1);
    tick(); tick();
    vecs++; if (stall !== 8'h24 || cdone !== 1'b0 || cready !== 1'b0) begin errs++;
      $display("FAIL d_hold stall=%h done=%b ready=%b want 24/0/0", stall, cdone, cready); end
    pulse_done(2, 3);
    vecs++; if (stall !== 8'h24 || cdone !== 1'b0) begin errs++;
      $display("FAIL d_cnt0 stall=%h done=%b want 24/0", stall, cdone); end
    tick();
    vecs++; if (stall !== 8'h24 || cdone !== 1'b0) begin errs++;
      $display("FAIL d_apply stall=%h done=%b want 24/0", stall, cdone); end
    tick();
    vecs++; if (cdone !== 1'b1 || cerr !== 1'b0 || stall !== 8'h00) begin errs++;
      $display("FAIL d_done done=%b err=%b stall=%h want 1/0/00", cdone, cerr, stall); end
  endtask

  task automatic test_timeout();
    int cyc = 0, guard = 0;
    pulse_start(2, 1);
    issue(6, 2, 1'b1);
    while (cdone !== 1'b1 && guard < 400) begin
      if (stall === 8'h44) cyc++;
      guard++;
      tick();
    end
    vecs++; if (cyc != 256) begin errs++;
      $display("FAIL to_cycles got %0d want 256", cyc); end
    vecs++; if (cdone !== 1'b1 || cerr !== 1'b1 || stall !== 8'h00 || cready !== 1'b1) begin errs++;
      $display("FAIL to_done done=%b err=%b stall=%h ready=%b want 1/1/00/1", cdone, cerr, stall, cready); end
    set_in(8'h04);
    vecs++; if (mout[0] !== 8'h20) begin errs++;
      $display("FAIL to_table got %h want 20", mout[0]); end
    pulse_done(2, 1);
  endtask

  task automatic test_bad_index();
    issue(9, 1, 1'b1);
    vecs++; if (cdone !== 1'b1 || cerr !== 1'b1 || stall !== 8'h00 || cready !== 1'b1) begin errs++;
      $display("FAIL bad_port done=%b err=%b stall=%h ready=%b want 1/1/00/1", cdone, cerr, stall, cready); end
    tick();
    vecs++; if (cdone !== 1'b0 || cready !== 1'b1 || stall !== 8'h00) begin errs++;
      $display("FAIL bad_port_after done=%b ready=%b stall=%h want 0/1/00", cdone, cready, stall); end
    issue(1, 12, 1'b1);
    vecs++; if (cdone !== 1'b1 || cerr !== 1'b1 || stall !== 8'h00) begin errs++;
      $display("FAIL bad_src done=%b err=%b stall=%h want 1/1/00", cdone, cerr, stall); end
    tick();
  endtask

  task automatic test_cnt_err();
    pulse_start(7, 15);
    vecs++; if (cnterr !== 1'b0) begin errs++;
      $display("FAIL cnt_max cnterr=%b want 0", cnterr); end
    pulse_start(7, 1);
    vecs++; if (cnterr !== 1'b1) begin errs++;
      $display("FAIL cnt_sat cnterr=%b want 1", cnterr); end
    pulse_done(0, 1);
    tick(); tick();
    vecs++; if (cnterr !== 1'b1) begin errs++;
      $display("FAIL cnt_sticky cnterr=%b want 1", cnterr); end
  endtask

  task automatic test_reset_mid_drain();
    int seen = 0;
    pulse_start(4, 1);
    issue(4, 1, 1'b1);
    tick();
    vecs++; if (stall !== 8'h12) begin errs++;
      $display("FAIL rst_pre stall=%h want 12", stall); end
    rst_n = 1'b0;
    #1;
    vecs++; if (stall !== 8'h00 || cready !== 1'b1 || cnterr !== 1'b0 || cdone !== 1'b0) begin errs++;
      $display("FAIL rst_async stall=%h ready=%b cnterr=%b done=%b want 00/1/0/0", stall, cready, cnterr, cdone); end
    set_in(8'h04);
    vecs++; if (mout[0] !== 8'h04) begin errs++;
      $display("FAIL rst_table got %h want 04", mout[0]); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (cdone === 1'b1) seen++;
      tick();
    end
    vecs++; if (seen != 0 || stall !== 8'h00) begin errs++;
      $display("FAIL rst_no_done pulses=%0d stall=%h want 0/00", seen, stall); end
  endtask

  initial begin
    rst_n = 1'b0; cvalid = 1'b0; cport = '0; csrc = '0; cen = 1'b0;
    tstart = '0; tdone = '0;
    for (int r = 0; r < R; r++) min[r] = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_map_quiescent();
    test_drain();
    test_timeout();
    test_bad_index();
    test_cnt_err();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
